// File: rtl/mips_mult_pkg.sv
// Shared state encoding and sizing helpers for the HI/LO multiply sequencer.
package mips_mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } mult_state_e;

    // Counter must hold the full cycle count K = width / bits.
    function automatic int unsigned cnt_width(input int unsigned width, input int unsigned bits);
        return $clog2(width / bits + 1);
    endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Shift-add multiply datapath on unsigned magnitudes; retires BITS_PER_CYCLE multiplier bits per step.
module mult_shift_add #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_done_zero
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    w_acc_next;
    logic [WIDTH-1:0] w_mplier_next;

    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (r_mplier[i]) begin
                w_acc_next = w_acc_next + (r_mcand << i);
            end
        end
    end

    assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;

    // Product and zero flag reflect the state after the step in progress.
    assign o_product   = w_acc_next;
    assign o_done_zero = (w_mplier_next == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= w_mplier_next;
        end
    end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Iterative MULT/MULTU sequencer with HI/LO registers and hazard stall.
// Define MULT_EARLY_TERM_EN to leave CALC once the remaining multiplier bits are all zero.
module hilo_mult_ctrl
    import mips_mult_pkg::*;
#(
    parameter int unsigned WIDTH          = MULT_WIDTH,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MultStartE,
    input  logic             MultSgnE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             MfHiE,
    input  logic             MfLoE,
    output logic [WIDTH-1:0] HiLoOutE,
    output logic             StallMult,
    output logic             MultBusy,
    output logic             MultComplete
);

    localparam int unsigned K  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW = cnt_width(WIDTH, BITS_PER_CYCLE);
    localparam int unsigned PW = 2 * WIDTH;

    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bits
        $error("hilo_mult_ctrl: BITS_PER_CYCLE must divide WIDTH");
    end

    mult_state_e      r_state;
    mult_state_e      w_state_next;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_prod;
    logic [PW-1:0]    w_prod_fix;
    logic             w_done_zero;

    // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
    assign w_a_neg = MultSgnE & SrcAE[WIDTH-1];
    assign w_b_neg = MultSgnE & SrcBE[WIDTH-1];
    assign w_a_mag = w_a_neg ? (WIDTH'(0) - SrcAE) : SrcAE;
    assign w_b_mag = w_b_neg ? (WIDTH'(0) - SrcBE) : SrcBE;

    mult_shift_add #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_datapath (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_mcand     (w_a_mag),
        .i_mplier    (w_b_mag),
        .o_product   (w_prod),
        .o_done_zero (w_done_zero)
    );

    assign w_prod_fix = r_neg ? (PW'(0) - w_prod) : w_prod;

`ifdef MULT_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(1)) || w_done_zero;
`else
    logic w_unused_done_zero;
    assign w_unused_done_zero = w_done_zero;
    assign w_last             = (r_cnt == CW'(1));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: w_state_next = MultStartE ? StCalc : StIdle;
            StCalc:         if (w_last) w_state_next = StDone;
            default:        w_state_next = StIdle;
        endcase
    end

    always_comb begin
        MultBusy     = (r_state == StCalc);
        MultComplete = (r_state == StDone);
        w_step       = (r_state == StCalc);
        w_load       = MultStartE && (r_state != StCalc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_neg <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_load) begin
                r_cnt <= CW'(K);
                r_neg <= w_a_neg ^ w_b_neg;
            end else if (w_step) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_step && w_last) begin
                r_hi <= w_prod_fix[PW-1:WIDTH];
                r_lo <= w_prod_fix[WIDTH-1:0];
            end
        end
    end

    assign StallMult = MultBusy & (MfHiE | MfLoE | MultStartE);
    assign HiLoOutE  = MfHiE ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Self-checking bench for hilo_mult_ctrl: arithmetic reference model plus directed literal checks.
module tb_hilo_mult_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        mfhi;
    logic        mflo;
    logic [31:0] hilo_out;
    logic        stall;
    logic        busy;
    logic        complete;

    int n_checks = 0;
    int n_errors = 0;

    hilo_mult_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .MultStartE   (start),
        .MultSgnE     (sgn),
        .SrcAE        (a),
        .SrcBE        (b),
        .MfHiE        (mfhi),
        .MfLoE        (mflo),
        .HiLoOutE     (hilo_out),
        .StallMult    (stall),
        .MultBusy     (busy),
        .MultComplete (complete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: full 64-bit product of the operands as integers.
    function automatic logic [63:0] model_prod(input logic s, input logic [31:0] x,
                                               input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return 64'(ux * uy);
    endfunction

    function automatic int lat_of(input logic s, input logic [31:0] y);
`ifdef MULT_EARLY_TERM_EN
        logic [31:0] m;
        int          n;
        m = (s && y[31]) ? (32'd0 - y) : y;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) n = i + 1;
        end
        return n;
`else
        if (s && y[31]) return 32;
        return 32;
`endif
    endfunction

    // Model: cycles left in the running op, pending result, architectural HI/LO.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_hi   <= m_pend[63:32];
                m_lo   <= m_pend[31:0];
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= lat_of(sgn, b);
                m_pend <= model_prod(sgn, a, b);
            end
        end
    end

    always @(negedge clk) begin
        chk("model_busy", 64'(busy), 64'(m_left > 0));
        chk("model_complete", 64'(complete), 64'(m_done));
        chk("model_stall", 64'(stall), 64'((m_left > 0) && (mfhi || mflo || start)));
        chk("model_hilo", 64'(hilo_out), 64'(mfhi ? m_hi : m_lo));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after the start edge until MultComplete shows; bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!complete && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        mfhi = 1'b1;
        #1 hi = hilo_out;
        mfhi = 1'b0;
        #1 lo = hilo_out;
    endtask

    task automatic run_mul(input string name, input logic s, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        issue(s, x, y);
        wait_done(cyc);
        chk({name, "_latency"}, 64'(cyc), 64'(lat_of(s, y)));
        read_hilo(hi, lo);
        chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        mfhi  = 1'b0;
        mflo  = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_complete", 64'(complete), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_hilo", 64'(hilo_out), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Unsigned 7*5 with literal latency
        issue(1'b0, 32'd7, 32'd5);
        wait_done(cyc);
`ifdef MULT_EARLY_TERM_EN
        chk("u7x5_latency", 64'(cyc), 64'd3);
`else
        chk("u7x5_latency", 64'(cyc), 64'd32);
`endif
        read_hilo(hi, lo);
        chk("u7x5_hi", 64'(hi), 64'h0);
        chk("u7x5_lo", 64'(lo), 64'h23);
        mfhi = 1'b1;
        mflo = 1'b1;
        #1 chk("both_sel_hi", 64'(hilo_out), 64'h0);
        mfhi = 1'b0;
        mflo = 1'b0;
        tick();

        run_mul("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        tick();
        run_mul("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        run_mul("s_min", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        tick();
        run_mul("s_mix", 1'b1, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        tick();

        // MFLO waiting on an in-flight multiply
        issue(1'b0, 32'h0000_1234, 32'h0000_0010);
        tick();
        mflo = 1'b1;
        n    = 0;
        cyc  = 0;
        while (!complete && cyc < 100) begin
            #1 if (stall) n++;
            tick();
            cyc++;
        end
`ifdef MULT_EARLY_TERM_EN
        chk("stall_cycles", 64'(n), 64'(lat_of(1'b0, 32'h10) - 1));
`else
        chk("stall_cycles", 64'(n), 64'd31);
`endif
        #1;
        chk("stall_in_done", 64'(stall), 64'd0);
        chk("mflo_in_done", 64'(hilo_out), 64'h0001_2340);
        mflo = 1'b0;
        tick();

        // Reset in the middle of CALC
        issue(1'b0, 32'hDEAD_BEEF, 32'h0000_0100);
        repeat (10) tick();
        rst = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_complete", 64'(complete), 64'd0);
        read_hilo(hi, lo);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        n   = 0;
        repeat (40) begin
            tick();
            if (complete) n++;
        end
        chk("midrst_no_complete", 64'(n), 64'd0);
        run_mul("post_rst", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        tick();

        // Back-to-back: second start issued in the DONE cycle
        issue(1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done(cyc);
        chk("b2b_first_latency", 64'(cyc), 64'(lat_of(1'b1, 32'h3)));
        issue(1'b0, 32'd100, 32'd200);
        cyc = 0;
        while (!complete && cyc < 100) begin
            if (cyc == 16) chk("b2b_hold_lo", 64'(hilo_out), 64'hFFFF_FFFA);
            tick();
            cyc++;
        end
`ifdef MULT_EARLY_TERM_EN
        chk("b2b_second_latency", 64'(cyc), 64'(lat_of(1'b0, 32'd200)));
`else
        chk("b2b_second_latency", 64'(cyc), 64'd32);
`endif
        read_hilo(hi, lo);
        chk("b2b_hi", 64'(hi), 64'h0);
        chk("b2b_lo", 64'(lo), 64'h0000_4E20);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_mult_ctrl.md
Name: hilo_mult_ctrl

Overview:
- Sequencer for the execute-stage iterative multiplier and the HI/LO architectural registers.
- Accepts a MULT/MULTU issue from the execute stage (MultStartE, MultSgnE) and runs a shift-add datapath for a fixed number of cycles.
- Writes the 64-bit product into HI/LO, pulses MultComplete, and raises StallMult to the hazard unit while an MFHI/MFLO would read a stale result.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- BITS_PER_CYCLE, 1, multiplier bits retired per CALC cycle; must divide WIDTH (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- MultStartE  input  1  issue a multiply this cycle
- MultSgnE  input  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with MultStartE
- SrcAE  input  WIDTH  multiplicand (forwarded rs value)
- SrcBE  input  WIDTH  multiplier (forwarded rt value)
- MfHiE  input  1  MFHI in execute
- MfLoE  input  1  MFLO in execute
- HiLoOutE  output  WIDTH  HI if MfHiE, else LO
- StallMult  output  1  stall request to hazard unit
- MultBusy  output  1  high in CALC
- MultComplete  output  1  one-cycle pulse, result valid in HI/LO

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, HI=0, LO=0.
  - MultBusy=0, MultComplete=0, StallMult=0, HiLoOutE=0.
  - Reset in mid-CALC abandons the operation; HI/LO still clear.
- States:
  - IDLE: MultStartE=1 at edge N latches operands, enters CALC, loads counter with K=WIDTH/BITS_PER_CYCLE.
  - CALC: each edge retires BITS_PER_CYCLE multiplier bits and decrements the counter. On the edge where the counter reaches 0, the final product is written to HI/LO and the state moves to DONE.
  - DONE: MultComplete=1 for exactly one cycle, then IDLE. MultStartE in DONE is accepted exactly as in IDLE (back-to-back issue).
- Latency: start at edge N -> HI/LO updated at edge N+K; MultComplete high during cycle N+K to N+K+1. WIDTH=32, BITS=1 gives K=32.
- Signed mode:
  - Datapath multiplies magnitudes |A|, |B| (2*WIDTH-bit unsigned).
  - Product is negated when sign(A) XOR sign(B).
  - -2^(WIDTH-1) magnitude is handled as an unsigned WIDTH-bit value with no overflow.
- Unsigned mode: zero-extended product.
- MultStartE during CALC: ignored; the in-flight op continues. The hazard unit must hold the issuing instruction, and StallMult is raised for it.
- StallMult = MultBusy & (MfHiE | MfLoE | MultStartE). It is combinational and never asserted in IDLE/DONE.
- HiLoOutE:
  - Combinational from HI/LO registers.
  - MfHiE and MfLoE both high selects HI.
  - Neither high outputs LO.
- HI/LO change only on the completing edge or on reset.

Optional Feature:
- Macro MULT_EARLY_TERM_EN.
- Defined:
  - CALC also exits when all remaining unretired multiplier bits are 0. The product is written on that edge, then DONE.
  - Latency becomes 1..K cycles; 7*5 completes in 3 CALC cycles (BITS=1).
- Undefined: fixed K-cycle CALC regardless of operand values.

Decomposition:
- Shared package mips_mult_pkg:
  - state enum (IDLE, CALC, DONE, 2-bit encoding)
  - WIDTH default constant
  - counter width function clog2(WIDTH/BITS_PER_CYCLE + 1)
- Sub-module mult_shift_add: the accumulate/shift datapath, with load, step, done_zero outputs and a 2*WIDTH product. hilo_mult_ctrl holds the FSM, counter, sign fix-up, HI/LO, and stall logic.

Test Plan:
- Unsigned 7*5, MultSgnE=0:
  - MultComplete exactly 32 cycles after the start edge.
  - HI=0x00000000, LO=0x00000023.
- Signed -3*5 (0xFFFFFFFD, 0x00000005): HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned and signed extremes:
  - Unsigned 0xFFFFFFFF*0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
  - Signed 0x80000000*0xFFFFFFFF gives HI=0x00000000, LO=0x80000000.
- MfLoE held high from start+1:
  - StallMult=1 for cycles start+1..start+31 and 0 in DONE.
  - HiLoOutE=new LO in DONE.
- rst driven low at CALC cycle 10:
  - Immediately MultBusy=0, HI=LO=0, no MultComplete.
  - A new start after release completes normally.
- Back-to-back starts: second MultStartE in the DONE cycle is accepted; second MultComplete is 32 cycles later, and HI/LO hold the first result until then.
